pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined two-operand adder/subtractor that generalises the team's ripple-carry adder. It splits the WIDTH-bit carry chain into STAGES registered chunks, which bounds the combinational carry path to WIDTH/STAGES bits. It adds an add/subtract mode, a signed-overflow flag and a valid/ready handshake on both sides, and it sits between operand producers and result consumers in the datapath.

## Interface
- WIDTH, 32, operand and result width in bits; must be ≥ 2.
- STAGES, 4, number of pipeline stages; must divide WIDTH exactly (elaboration error otherwise).
- CHUNK, WIDTH/STAGES, derived localparam: bits added per stage.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous and active-low.
- in_valid  input  1  operand beat offered.
- in_ready  output  1  pipeline can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used in add mode only.
- sub  input  1  0 selects A+B+cin; 1 selects A−B.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  raw carry out of the MSB (in sub mode, 1 means no borrow).
- ovf  output  1  signed two's-complement overflow.

## Operation
- The effective B operand is b when sub=0 and ~b when sub=1.
- The effective carry-in is cin when sub=0 and 1 when sub=1; cin is ignored in sub mode.
- Stage k (k = 0..STAGES−1) adds chunk k of A and effective B, plus the carry registered from stage k−1. Stage 0 uses the effective carry-in.
- Unprocessed upper operand chunks travel forward in skew registers.
- Completed lower sum chunks travel forward in deskew registers.
- Each stage holds one valid bit.
- cout is the carry out of the final chunk.
- ovf = (carry into the MSB) XOR (carry out of the MSB), computed in the final stage.
- Results are exact modulo 2^WIDTH; there is no saturation.
- Global-stall pipeline: advance = !out_valid || out_ready.
  - All stages shift together when advance is 1.
  - in_ready = advance.
  - Bubbles are not collapsed; an empty stage shifts as valid=0.
- A beat is accepted when in_valid && in_ready.
- Results leave in the same order as beats were accepted; no beat is dropped or duplicated.
- STAGES=1 is legal: a full-width combinational add followed by one output register.

## Timing
- Latency: a beat accepted at edge T appears with out_valid=1 after edge T+STAGES−1, i.e. STAGES cycles, provided advance stays 1.
- Throughput: one beat per cycle while out_ready=1.
- While out_valid && !out_ready:
  - sum, cout and ovf hold stable.
  - in_ready=0.
  - Every stage register holds its value.
- A result transfers on out_valid && out_ready. If the next stage is valid, it is presented at the following edge with no gap.
- Reset (rst_n=0), asynchronous:
  - All valid bits clear immediately.
  - out_valid=0, sum=0, cout=0, ovf=0.
  - All skew, deskew and carry registers are cleared to 0.
  - in_ready=1 once the pipeline is empty, including during reset.
- Reset asserted mid-stream flushes every in-flight beat with no partial output. The first beat after reset release sees an empty pipe.
- in_valid=1 while in_ready=0: the beat is not accepted. The producer must hold it; the block takes no action.

## Structure
- Package adder_pkg holds:
  - a function that checks the legality of WIDTH and STAGES;
  - the typedef alu_op_e (OP_ADD=0, OP_SUB=1) that drives the sub port.
- Sub-module chunk_adder: combinational CHUNK-bit adder.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, and c_msb (the carry into its MSB).
  - Built from the existing full_adder cells.
  - Instantiated once per stage via generate.
- pipelined_adder owns all registers, the handshake logic and the sub/carry-in muxing.

## Test plan
All scenarios use WIDTH=32, STAGES=4 unless stated otherwise.
- Reset check: during and after reset → out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
- Full carry ripple: add 0xFFFFFFFF + 0x00000001, cin=0 → 4 cycles later sum=0x00000000, cout=1, ovf=0. This proves carry crosses all chunk boundaries.
- Subtract with overflow: 0x80000000 − 0x00000001 → sum=0x7FFFFFFF, cout=1, ovf=1. Also 0x00000000 − 0x00000001 → sum=0xFFFFFFFF, cout=0, ovf=0.
- Streaming: 8 back-to-back random beats with out_ready=1 → 8 results on 8 consecutive cycles, in order, each matching the reference model.
- Backpressure: fill the pipe, then hold out_ready=0 for 3 cycles → in_ready=0, sum/cout/ovf stable for those cycles, then results resume with no loss or duplication.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight → out_valid drops to 0 immediately and no flushed result appears after release. Repeat the streaming test with STAGES=1 and STAGES=32: latency is 1 and 32 cycles respectively.

Source files
------------

// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared types and helpers for the pipelined adder family.
//   alu_op_e    : operation select that drives the adder's sub port
//   paramsLegal : elaboration-time legality check for WIDTH / STAGES
// ---------------------------------------------------------------------------
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } alu_op_e;

  // A chunked carry chain only works when the chunks tile the word exactly.
  function automatic bit paramsLegal(input int width, input int stages);
    return (width >= 2) && (stages >= 1) && (stages <= width) &&
           ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// ---------------------------------------------------------------------------
// chunk_adder
// Combinational W-bit ripple-carry adder built from full_adder cells.
//   a, b  : W-bit addends
//   cin   : carry into bit 0
//   sum   : W-bit sum
//   cout  : carry out of bit W-1
//   c_msb : carry into bit W-1 (used by the caller for signed overflow)
// ---------------------------------------------------------------------------
module chunk_adder
  import adder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (w_carry[i]),
      .sum (sum[i]),
      .cout(w_carry[i+1])
    );
  end

  assign cout  = w_carry[W];
  assign c_msb = w_carry[W-1];

endmodule

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// Single-bit full adder cell used to build ripple chains.
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
// ---------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_adder.sv
// ---------------------------------------------------------------------------
// pipelined_adder
// WIDTH-bit adder/subtractor whose carry chain is split into STAGES registered
// chunks, with valid/ready handshakes on input and output.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand beat handshake
//   a, b, cin, sub      : operands, carry in (add only), subtract select
//   out_valid/out_ready : result beat handshake
//   sum, cout, ovf      : result, raw MSB carry out, signed overflow
// ---------------------------------------------------------------------------
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  if (!paramsLegal(WIDTH, STAGES)) begin : g_badParams
    $error("pipelined_adder: WIDTH must be >= 2 and divisible by STAGES");
  end

  alu_op_e          w_op;
  logic [WIDTH-1:0] w_bEff;
  logic             w_cinEff;
  logic             w_advance;

  // Subtraction is A + ~B + 1, so the carry-in is forced high in sub mode.
  assign w_op     = alu_op_e'(sub);
  assign w_bEff   = (w_op == OP_SUB) ? ~b : b;
  assign w_cinEff = (w_op == OP_SUB) ? 1'b1 : cin;

  // Global stall: the whole pipe moves only when the output slot can drain.
  assign w_advance = !out_valid || out_ready;

  logic             r_vld   [STAGES];
  logic             r_carry [STAGES];
  logic [WIDTH-1:0] r_a     [STAGES];
  logic [WIDTH-1:0] r_b     [STAGES];
  logic [WIDTH-1:0] r_sum   [STAGES];
  logic             r_ovf;

  logic             w_vldIn    [STAGES];
  logic [WIDTH-1:0] w_aIn      [STAGES];
  logic [WIDTH-1:0] w_bIn      [STAGES];
  logic [WIDTH-1:0] w_sumIn    [STAGES];
  logic [WIDTH-1:0] w_sumMerged[STAGES];
  logic [CHUNK-1:0] w_chunkSum [STAGES];
  logic             w_chunkCin [STAGES];
  logic             w_chunkCout[STAGES];
  logic             w_chunkCmsb[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Stage 0 reads the ports directly; later stages read the previous
    // stage's skew (operands), deskew (partial sum) and carry registers.
    if (k == 0) begin : g_first
      assign w_vldIn[k]    = in_valid;
      assign w_aIn[k]      = a;
      assign w_bIn[k]      = w_bEff;
      assign w_sumIn[k]    = '0;
      assign w_chunkCin[k] = w_cinEff;
    end else begin : g_later
      assign w_vldIn[k]    = r_vld[k-1];
      assign w_aIn[k]      = r_a[k-1];
      assign w_bIn[k]      = r_b[k-1];
      assign w_sumIn[k]    = r_sum[k-1];
      assign w_chunkCin[k] = r_carry[k-1];
    end

    chunk_adder #(
      .W(CHUNK)
    ) u_chunk (
      .a    (w_aIn[k][k*CHUNK +: CHUNK]),
      .b    (w_bIn[k][k*CHUNK +: CHUNK]),
      .cin  (w_chunkCin[k]),
      .sum  (w_chunkSum[k]),
      .cout (w_chunkCout[k]),
      .c_msb(w_chunkCmsb[k])
    );

    // Drop this stage's chunk into its slot of the travelling partial sum.
    assign w_sumMerged[k] = (w_sumIn[k] & ~(WIDTH'({CHUNK{1'b1}}) << (k*CHUNK))) |
                            (WIDTH'(w_chunkSum[k]) << (k*CHUNK));
  end

  // All stage registers shift together on advance and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k]   <= 1'b0;
        r_carry[k] <= 1'b0;
        r_a[k]     <= '0;
        r_b[k]     <= '0;
        r_sum[k]   <= '0;
      end
      r_ovf <= 1'b0;
    end else if (w_advance) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k]   <= w_vldIn[k];
        r_carry[k] <= w_chunkCout[k];
        r_a[k]     <= w_aIn[k];
        r_b[k]     <= w_bIn[k];
        r_sum[k]   <= w_sumMerged[k];
      end
      r_ovf <= w_chunkCmsb[STAGES-1] ^ w_chunkCout[STAGES-1];
    end
  end

  assign in_ready  = w_advance;
  assign out_valid = r_vld[STAGES-1];
  assign sum       = r_sum[STAGES-1];
  assign cout      = r_carry[STAGES-1];
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_adder
// Drives three pipelined_adder instances (STAGES = 4, 1, 32; WIDTH = 32) that
// share the operand and reset inputs but have their own handshake signals.
// Expected results come from a signed/unsigned arithmetic model.
// ---------------------------------------------------------------------------
module tb_pipelined_adder;

  localparam int NDUT = 3;

  logic        clk;
  logic        rstN;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;

  logic        inValid [NDUT];
  logic        inReady [NDUT];
  logic        outValid[NDUT];
  logic        outReady[NDUT];
  logic [31:0] sumOut  [NDUT];
  logic        coutOut [NDUT];
  logic        ovfOut  [NDUT];

  int vectors     = 0;
  int miscompares = 0;

  logic [33:0] expQ0[$];
  logic [33:0] expQ1[$];
  logic [33:0] expQ2[$];

  pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut4 (
    .clk(clk), .rst_n(rstN), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(outValid[0]), .out_ready(outReady[0]),
    .sum(sumOut[0]), .cout(coutOut[0]), .ovf(ovfOut[0])
  );

  pipelined_adder #(.WIDTH(32), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rstN), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(outValid[1]), .out_ready(outReady[1]),
    .sum(sumOut[1]), .cout(coutOut[1]), .ovf(ovfOut[1])
  );

  pipelined_adder #(.WIDTH(32), .STAGES(32)) u_dut32 (
    .clk(clk), .rst_n(rstN), .in_valid(inValid[2]), .in_ready(inReady[2]),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(outValid[2]), .out_ready(outReady[2]),
    .sum(sumOut[2]), .cout(coutOut[2]), .ovf(ovfOut[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a hung handshake.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int stagesOf(input int d);
    case (d)
      0:       return 4;
      1:       return 1;
      default: return 32;
    endcase
  endfunction

  // Result as {ovf, cout, sum}, computed from the arithmetic meaning of the
  // operation rather than from a carry chain.
  function automatic logic [33:0] refModel(input logic [31:0] x, input logic [31:0] y,
                                           input logic c, input logic s);
    longint sx, sy, ux, uy, sres, ures;
    logic   co, ov;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    if (!s) begin
      ures = ux + uy + longint'(c);
      sres = sx + sy + longint'(c);
      co   = (ures >= (longint'(1) << 32));
    end else begin
      ures = ux - uy;
      sres = sx - sy;
      co   = (ux >= uy);
    end
    ov = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
    return {ov, co, ures[31:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int qSize(input int d);
    case (d)
      0:       return expQ0.size();
      1:       return expQ1.size();
      default: return expQ2.size();
    endcase
  endfunction

  task automatic pushExp(input int d, input logic [33:0] v);
    case (d)
      0:       expQ0.push_back(v);
      1:       expQ1.push_back(v);
      default: expQ2.push_back(v);
    endcase
  endtask

  task automatic popExp(input int d, output logic [33:0] v);
    case (d)
      0:       v = expQ0.pop_front();
      1:       v = expQ1.pop_front();
      default: v = expQ2.pop_front();
    endcase
  endtask

  task automatic flushExp();
    expQ0.delete();
    expQ1.delete();
    expQ2.delete();
  endtask

  // One clock: note every handshake that completes at the coming edge,
  // score transferred results against the model, then sample #1 after it.
  task automatic tick();
    bit          acc [NDUT];
    bit          xfer[NDUT];
    logic [33:0] expV;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      acc[d]  = inValid[d] && inReady[d];
      xfer[d] = outValid[d] && outReady[d];
    end
    for (int d = 0; d < NDUT; d++) begin
      if (xfer[d]) begin
        checkOutput($sformatf("resultPending_s%0d", stagesOf(d)), 64'(qSize(d) != 0), 64'd1);
        if (qSize(d) != 0) begin
          popExp(d, expV);
          checkOutput($sformatf("result_s%0d", stagesOf(d)),
                      64'({ovfOut[d], coutOut[d], sumOut[d]}), 64'(expV));
        end
      end
      if (acc[d]) pushExp(d, refModel(a, b, cin, sub));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int d, input logic v, input logic [31:0] aa,
                               input logic [31:0] bb, input logic c, input logic s);
    a          = aa;
    b          = bb;
    cin        = c;
    sub        = s;
    inValid[d] = v;
  endtask

  // Single beat into an idle pipe; reports how many edges until out_valid.
  task automatic sendAndWait(input int d, input logic [31:0] aa, input logic [31:0] bb,
                             input logic c, input logic s);
    int lat;
    applyStimulus(d, 1'b1, aa, bb, c, s);
    tick();
    inValid[d] = 1'b0;
    lat = 1;
    while (!outValid[d] && lat < 40) begin
      tick();
      lat++;
    end
    checkOutput($sformatf("latency_s%0d", stagesOf(d)), 64'(lat), 64'(stagesOf(d)));
  endtask

  task automatic streamTest(input int d);
    int first, cnt, last, span;
    first = -1;
    cnt   = 0;
    last  = -1;
    span  = 8 + stagesOf(d) + 4;
    outReady[d] = 1'b1;
    for (int i = 0; i <= span; i++) begin
      if (i < 8)
        applyStimulus(d, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
      else
        inValid[d] = 1'b0;
      tick();
      if (outValid[d]) begin
        if (first < 0) first = i + 1;
        cnt++;
        last = i + 1;
      end
    end
    checkOutput($sformatf("streamLatency_s%0d", stagesOf(d)), 64'(first), 64'(stagesOf(d)));
    checkOutput($sformatf("streamCount_s%0d", stagesOf(d)), 64'(cnt), 64'd8);
    checkOutput($sformatf("streamGapless_s%0d", stagesOf(d)), 64'(last - first), 64'd7);
  endtask

  initial begin
    logic [33:0] snap;

    rstN = 1'b1;
    a    = '0;
    b    = '0;
    cin  = 1'b0;
    sub  = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      inValid[d]  = 1'b0;
      outReady[d] = 1'b1;
    end

    // Reset state, both before and after a clock edge inside reset.
    #1 rstN = 1'b0;
    #2;
    checkOutput("resetOutputs", 64'({outValid[0], ovfOut[0], coutOut[0], sumOut[0]}), 64'd0);
    checkOutput("resetInReady", 64'({inReady[0], inReady[1], inReady[2]}), 64'b111);
    @(posedge clk);
    #1;
    checkOutput("resetHeldOutputs", 64'({outValid[0], ovfOut[0], coutOut[0], sumOut[0]}), 64'd0);
    checkOutput("resetHeldValid", 64'({outValid[1], outValid[2]}), 64'd0);
    rstN = 1'b1;
    tick();

    // Carry must ripple across every chunk boundary.
    sendAndWait(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    checkOutput("carryRipple", 64'({ovfOut[0], coutOut[0], sumOut[0]}), 64'({1'b0, 1'b1, 32'h0000_0000}));
    tick();

    // Subtraction boundaries: signed overflow, and borrow with no overflow.
    sendAndWait(0, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    checkOutput("subOverflow", 64'({ovfOut[0], coutOut[0], sumOut[0]}), 64'({1'b1, 1'b1, 32'h7FFF_FFFF}));
    tick();
    sendAndWait(0, 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1);
    checkOutput("subBorrow", 64'({ovfOut[0], coutOut[0], sumOut[0]}), 64'({1'b0, 1'b0, 32'hFFFF_FFFF}));
    tick();

    // Positive + positive overflow with carry-in.
    sendAndWait(0, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    checkOutput("addOverflowCin", 64'({ovfOut[0], coutOut[0], sumOut[0]}), 64'({1'b1, 1'b0, 32'h8000_0000}));
    tick();

    // Back-to-back random beats on every depth.
    streamTest(0);
    streamTest(1);
    streamTest(2);

    // Fill the pipe, then stall the consumer for three cycles.
    outReady[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end
    checkOutput("bpFull", 64'(outValid[0]), 64'd1);
    outReady[0] = 1'b0;
    applyStimulus(0, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    snap = {ovfOut[0], coutOut[0], sumOut[0]};
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("bpInReady", 64'(inReady[0]), 64'd0);
      tick();
      checkOutput("bpHold", 64'({outValid[0], ovfOut[0], coutOut[0], sumOut[0]}), 64'({1'b1, snap}));
    end
    outReady[0] = 1'b1;
    tick();
    inValid[0] = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checkOutput("bpDrained", 64'(qSize(0)), 64'd0);

    // Reset with one result presented and three beats still in flight.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end
    inValid[0] = 1'b0;
    checkOutput("preResetValid", 64'(outValid[0]), 64'd1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midResetOutputs", 64'({outValid[0], ovfOut[0], coutOut[0], sumOut[0]}), 64'd0);
    checkOutput("midResetInReady", 64'(inReady[0]), 64'd1);
    flushExp();
    @(posedge clk);
    #1 rstN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("postResetEmpty", 64'(outValid[0]), 64'd0);
    end
    sendAndWait(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    checkOutput("postResetBeat", 64'({ovfOut[0], coutOut[0], sumOut[0]}), 64'({1'b0, 1'b0, 32'h2345_6789}));
    for (int i = 0; i < 4; i++) tick();

    checkOutput("finalQueue_s4", 64'(qSize(0)), 64'd0);
    checkOutput("finalQueue_s1", 64'(qSize(1)), 64'd0);
    checkOutput("finalQueue_s32", 64'(qSize(2)), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
